// File: rtl/lib_pipe_pkg.sv
// Shared latency math for the staged-chain register inserter and its aligner.
package lib_pipe_pkg;

  localparam int ERR_CNT_W = 16;

  // Number of pipeline registers the inserter places along the chain.
  function automatic int ff_num(input int stage_num, input int ff_step);
    return stage_num / ff_step - 1;
  endfunction

  // Registers seen between the chain input and tap i.
  function automatic int tap_lat(input int i, input int ff_step, input int ff_num_v);
    int l;
    l = (i + 1) / ff_step;
    return (l < ff_num_v) ? l : ff_num_v;
  endfunction

endpackage

// File: rtl/lib_delay_line.sv
// Fixed-depth delay for one tap: async-reset valid bits, free-running data stages.
module lib_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] data_i,
  input  logic             vld_i,
  output logic [WIDTH-1:0] data_o,
  output logic             vld_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rstn;
    assign data_o = data_i;
    assign vld_o  = vld_i;
  end else begin : g_regs
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= vld_i;
        for (int k = 1; k < DEPTH; k++) vld_q[k] <= vld_q[k-1];
      end
    end

    // Data is only meaningful alongside its valid, so it carries no reset.
    always_ff @(posedge clk) begin
      data_q[0] <= data_i;
      for (int k = 1; k < DEPTH; k++) data_q[k] <= data_q[k-1];
    end

    assign data_o = data_q[DEPTH-1];
    assign vld_o  = vld_q[DEPTH-1];
  end

endmodule

// File: rtl/lib_pipe_align.sv
// Re-aligns staged-chain taps to the deepest tap and flags incoherent valids.
// Optional mismatch counter enabled by defining LIB_PIPE_ALIGN_ERR_CNT_EN.
module lib_pipe_align
  import lib_pipe_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STAGE_NUM = 8,
  parameter int FF_STEP   = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [WIDTH-1:0]     data_i [STAGE_NUM-1],
  input  logic [STAGE_NUM-2:0] vld_i,
  output logic [WIDTH-1:0]     data_o [STAGE_NUM-1],
  output logic [STAGE_NUM-2:0] vld_o,
  output logic                 all_vld_o,
  input  logic                 err_clr_i,
  output logic                 err_o
`ifdef LIB_PIPE_ALIGN_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt_o
`endif
);

  localparam int FF_NUM = ff_num(STAGE_NUM, FF_STEP);

  if (FF_STEP > STAGE_NUM - 1) begin : g_chk_step
    $fatal(1, "lib_pipe_align: FF_STEP exceeds the number of taps");
  end
  if (FF_NUM < 0) begin : g_chk_ffnum
    $fatal(1, "lib_pipe_align: negative register count");
  end

  // Shallow taps wait for the deepest one.
  for (genvar i = 0; i < STAGE_NUM - 1; i++) begin : g_tap
    localparam int D = FF_NUM - tap_lat(i, FF_STEP, FF_NUM);
    lib_delay_line #(
      .WIDTH (WIDTH),
      .DEPTH (D)
    ) u_dl (
      .clk    (clk),
      .rstn   (rstn),
      .data_i (data_i[i]),
      .vld_i  (vld_i[i]),
      .data_o (data_o[i]),
      .vld_o  (vld_o[i])
    );
  end

  logic mismatch;
  logic err_q, err_d;

  assign all_vld_o = &vld_o;
  assign mismatch  = (|vld_o) & ~(&vld_o);
  assign err_d     = mismatch | (err_q & ~err_clr_i);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err_o = err_q;

`ifdef LIB_PIPE_ALIGN_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  // A mismatch in the clearing cycle still counts, so the counter restarts at 1.
  always_comb begin
    cnt_d = cnt_q;
    if (err_clr_i)
      cnt_d = {{(ERR_CNT_W-1){1'b0}}, mismatch};
    else if (mismatch && (cnt_q != {ERR_CNT_W{1'b1}}))
      cnt_d = cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign err_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_lib_pipe_align.sv
// Directed bench: 12-stage aligner driven from a vector table, plus an 8-stage instance.
module tb_lib_pipe_align;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;

  logic [7:0]  data_a [11];
  logic [7:0]  dout_a [11];
  logic [10:0] vld_a, vout_a;
  logic        all_a, clr_a, err_a;

  logic [7:0]  data_b [7];
  logic [7:0]  dout_b [7];
  logic [6:0]  vld_b, vout_b;
  logic        all_b, clr_b, err_b;

`ifdef LIB_PIPE_ALIGN_ERR_CNT_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  lib_pipe_align #(.WIDTH(8), .STAGE_NUM(12), .FF_STEP(4)) dut_a (
    .clk       (clk),
    .rstn      (rstn),
    .data_i    (data_a),
    .vld_i     (vld_a),
    .data_o    (dout_a),
    .vld_o     (vout_a),
    .all_vld_o (all_a),
    .err_clr_i (clr_a),
    .err_o     (err_a)
`ifdef LIB_PIPE_ALIGN_ERR_CNT_EN
    ,
    .err_cnt_o (cnt_a)
`endif
  );

  lib_pipe_align #(.WIDTH(8), .STAGE_NUM(8), .FF_STEP(4)) dut_b (
    .clk       (clk),
    .rstn      (rstn),
    .data_i    (data_b),
    .vld_i     (vld_b),
    .data_o    (dout_b),
    .vld_o     (vout_b),
    .all_vld_o (all_b),
    .err_clr_i (clr_b),
    .err_o     (err_b)
`ifdef LIB_PIPE_ALIGN_ERR_CNT_EN
    ,
    .err_cnt_o (cnt_b)
`endif
  );

  typedef struct {
    logic [10:0] vin;
    logic        clr;
    logic [10:0] ovld;
    logic        oall;
    logic        oerr;
    logic [15:0] ocnt;
  } vec_t;

  vec_t tbl [19];
  int   vec_cnt  = 0;
  int   miss_cnt = 0;

  // Alignment delay of tap i in the 12-stage instance.
  function automatic int d_a(input int i);
    if (i < 3) return 2;
    if (i < 7) return 1;
    return 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic set(input int v, input logic [10:0] vi, input logic c, input logic [10:0] vo,
                     input logic a, input logic e, input logic [15:0] n);
    tbl[v].vin  = vi;
    tbl[v].clr  = c;
    tbl[v].ovld = vo;
    tbl[v].oall = a;
    tbl[v].oerr = e;
    tbl[v].ocnt = n;
  endtask

  initial begin
    int cyc;
    rstn  = 1'b0;
    clr_a = 1'b0;
    clr_b = 1'b0;
    vld_a = '0;
    vld_b = '0;
    for (int i = 0; i < 11; i++) data_a[i] = '0;
    for (int i = 0; i < 7; i++)  data_b[i] = '0;

    // five coherent words streamed back to back
    set( 0, 11'h007, 0, 11'h000, 0, 0, 0);
    set( 1, 11'h07F, 0, 11'h000, 0, 0, 0);
    set( 2, 11'h7FF, 0, 11'h7FF, 1, 0, 0);
    set( 3, 11'h7FF, 0, 11'h7FF, 1, 0, 0);
    set( 4, 11'h7FF, 0, 11'h7FF, 1, 0, 0);
    set( 5, 11'h7F8, 0, 11'h7FF, 1, 0, 0);
    set( 6, 11'h780, 0, 11'h7FF, 1, 0, 0);
    set( 7, 11'h000, 0, 11'h000, 0, 0, 0);
    // lone tap 5 valid, sticky error, then clear
    set( 8, 11'h020, 0, 11'h000, 0, 0, 0);
    set( 9, 11'h000, 0, 11'h020, 0, 0, 0);
    set(10, 11'h000, 0, 11'h000, 0, 1, 1);
    set(11, 11'h000, 0, 11'h000, 0, 1, 1);
    set(12, 11'h000, 1, 11'h000, 0, 1, 1);
    set(13, 11'h000, 0, 11'h000, 0, 0, 0);
    // mismatch in the same cycle as clear
    set(14, 11'h080, 0, 11'h080, 0, 0, 0);
    set(15, 11'h080, 1, 11'h080, 0, 1, 1);
    set(16, 11'h000, 0, 11'h000, 0, 1, 1);
    set(17, 11'h000, 1, 11'h000, 0, 1, 1);
    set(18, 11'h000, 0, 11'h000, 0, 0, 0);

    #12;
    chk("rst_vld", 32'(vout_a), 0);
    chk("rst_all", 32'(all_a), 0);
    chk("rst_err", 32'(err_a), 0);
`ifdef LIB_PIPE_ALIGN_ERR_CNT_EN
    chk("rst_cnt", 32'(cnt_a), 0);
`endif
    vld_a     = 11'h780;
    data_a[9] = 8'h5A;
    #1;
    chk("rst_pass_vld", 32'(vout_a), 32'h780);
    chk("rst_pass_data", 32'(dout_a[9]), 32'h5A);
    vld_a = '0;
    @(negedge clk);
    rstn = 1'b1;

    // 8-stage instance: one coherent word
    @(posedge clk); #1;
    vld_b = 7'h07;
    for (int i = 0; i < 3; i++) data_b[i] = 8'(16 + i);
    @(negedge clk);
    chk("b_pre_vld", 32'(vout_b), 0);
    @(posedge clk); #1;
    vld_b = 7'h78;
    for (int i = 0; i < 3; i++) data_b[i] = 8'hEE;
    for (int i = 3; i < 7; i++) data_b[i] = 8'(16 + i);
    @(negedge clk);
    chk("b_vld", 32'(vout_b), 32'h7F);
    chk("b_all", 32'(all_b), 1);
    chk("b_err", 32'(err_b), 0);
    for (int i = 0; i < 7; i++) chk($sformatf("b_data%0d", i), 32'(dout_b[i]), 32'(16 + i));
    @(posedge clk); #1;
    vld_b = '0;
    @(negedge clk);
    chk("b_post_vld", 32'(vout_b), 0);
    chk("b_post_err", 32'(err_b), 0);

    // 12-stage table
    @(posedge clk); #1;
    for (int v = 0; v < 19; v++) begin
      cyc   = 16 + v;
      vld_a = tbl[v].vin;
      clr_a = tbl[v].clr;
      for (int i = 0; i < 11; i++) data_a[i] = 8'(((cyc % 16) * 16) + i);
      @(negedge clk);
      chk($sformatf("v%0d_vld", v), 32'(vout_a), 32'(tbl[v].ovld));
      chk($sformatf("v%0d_all", v), 32'(all_a), 32'(tbl[v].oall));
      chk($sformatf("v%0d_err", v), 32'(err_a), 32'(tbl[v].oerr));
`ifdef LIB_PIPE_ALIGN_ERR_CNT_EN
      chk($sformatf("v%0d_cnt", v), 32'(cnt_a), 32'(tbl[v].ocnt));
`endif
      for (int i = 0; i < 11; i++)
        if (tbl[v].ovld[i])
          chk($sformatf("v%0d_data%0d", v, i), 32'(dout_a[i]),
              32'((((cyc - d_a(i)) % 16) * 16) + i));
      @(posedge clk); #1;
    end
    clr_a = 1'b0;

    // async reset with a word in flight and the error flag set
    vld_a = 11'h020;
    @(posedge clk); #1;
    vld_a = 11'h007;
    @(negedge clk);
    chk("rs_vld5", 32'(vout_a), 32'h020);
    @(posedge clk); #1;
    vld_a = 11'h078;
    @(negedge clk);
    chk("rs_err_pre", 32'(err_a), 1);
`ifdef LIB_PIPE_ALIGN_ERR_CNT_EN
    chk("rs_cnt_pre", 32'(cnt_a), 1);
`endif
    #1;
    rstn  = 1'b0;
    vld_a = '0;
    #1;
    chk("rs_vld", 32'(vout_a), 0);
    chk("rs_all", 32'(all_a), 0);
    chk("rs_err", 32'(err_a), 0);
`ifdef LIB_PIPE_ALIGN_ERR_CNT_EN
    chk("rs_cnt", 32'(cnt_a), 0);
`endif
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rs_flush%0d", k), 32'(vout_a), 0);
    end
    chk("rs_err_post", 32'(err_a), 0);

`ifdef LIB_PIPE_ALIGN_ERR_CNT_EN
    // counter saturation
    @(posedge clk); #1;
    vld_a = 11'h080;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", 32'(cnt_a), 32'hFFFE);
    @(posedge clk); #1;
    chk("sat_ffff", 32'(cnt_a), 32'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_hold", 32'(cnt_a), 32'hFFFF);
    vld_a = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
